// File: rtl/dma_copy_master.sv
// rtl/dma_copy_master.sv - byte-copy bus initiator sharing the CPU memory bus via request/grant
// Each byte is one READ beat then one WRITE beat; losing grant abandons the beat and re-reads the byte.
module dma_copy_master #(
  parameter int READ_WAIT    = 1,
  parameter int LENGTH_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [23:0]             src_address,
  input  logic [23:0]             dst_address,
  input  logic [LENGTH_WIDTH-1:0] length,
  output logic                    busy,
  output logic                    done,
  output logic                    bus_request,
  input  logic                    bus_grant,
  output logic [23:0]             address,
  output logic [7:0]              data_out,
  input  logic [7:0]              data_in,
  output logic                    bus_enable,
  output logic                    write_enable,
  input  logic                    bus_halt
);

  localparam int WW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [23:0]             src_q, src_d;
  logic [23:0]             dst_q, dst_d;
  logic [LENGTH_WIDTH-1:0] count_q, count_d;
  logic [7:0]              byte_q, byte_d;
  logic [WW-1:0]           wait_q, wait_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      byte_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      byte_q  <= byte_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    count_d      = count_q;
    byte_d       = byte_q;
    wait_d       = wait_q;
    busy         = (state_q != S_IDLE);
    done         = 1'b0;
    bus_request  = 1'b0;
    address      = '0;
    data_out     = '0;
    bus_enable   = 1'b0;
    write_enable = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            src_d   = src_address;
            dst_d   = dst_address;
            count_d = length;
            wait_d  = '0;
            state_d = S_REQUEST;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_REQUEST: begin
        bus_request = 1'b1;
        if (bus_grant) state_d = S_READ;
      end

      S_READ: begin
        bus_request = 1'b1;
        bus_enable  = 1'b1;
        address     = src_q;
        // Grant loss discards the partial wait so the restarted beat waits in full.
        if (!bus_grant) begin
          wait_d  = '0;
          state_d = S_REQUEST;
        end else if (!bus_halt) begin
          if (wait_q == WW'(READ_WAIT - 1)) begin
            byte_d  = data_in;
            wait_d  = '0;
            state_d = S_WRITE;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end

      S_WRITE: begin
        bus_request  = 1'b1;
        bus_enable   = 1'b1;
        write_enable = 1'b1;
        address      = dst_q;
        data_out     = byte_q;
        if (!bus_grant) begin
          state_d = S_REQUEST;
        end else if (!bus_halt) begin
          src_d   = src_q + 24'd1;
          dst_d   = dst_q + 24'd1;
          count_d = count_q - 1'b1;
          state_d = (count_q == LENGTH_WIDTH'(1)) ? S_DONE : S_READ;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_copy_master.sv
// tb/tb_dma_copy_master.sv - directed bench with a byte-level copy model checked every cycle
module tb_dma_copy_master;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [23:0] src_address, dst_address;
  logic [15:0] length;
  logic        busy, done, bus_request, bus_grant;
  logic [23:0] address;
  logic [7:0]  data_out, data_in;
  logic        bus_enable, write_enable, bus_halt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int st_cyc;

  logic [23:0] m_src, m_dst;
  int          m_len, m_k;
  bit          mon_en = 1'b0;
  int          en_cnt, wr_cnt, req_cnt, done_cnt, hold_cnt;
  logic [23:0] rd_log[$];
  logic [23:0] wr_log[$];
  logic [7:0]  wr_dlog[$];

  dma_copy_master dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .src_address  (src_address),
    .dst_address  (dst_address),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .bus_request  (bus_request),
    .bus_grant    (bus_grant),
    .address      (address),
    .data_out     (data_out),
    .data_in      (data_in),
    .bus_enable   (bus_enable),
    .write_enable (write_enable),
    .bus_halt     (bus_halt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  assign data_in = mem_byte(address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Byte k of the current copy is always read from src+k and written to dst+k.
  always @(negedge clk) begin : monitor
    logic [23:0] ea;
    if (mon_en) begin
      chk("req_rule", bus_request, busy && !done);
      if (bus_request) req_cnt++;
      if (bus_enable) begin
        en_cnt++;
        ea = write_enable ? m_dst + 24'(m_k) : m_src + 24'(m_k);
        chk("beat_addr", address, ea);
        if (write_enable) begin
          chk("wr_data", data_out, mem_byte(m_src + 24'(m_k)));
          if (bus_grant && !bus_halt) begin
            wr_cnt++;
            wr_log.push_back(address);
            wr_dlog.push_back(data_out);
            m_k++;
          end
        end else begin
          if (address == 24'h010000) hold_cnt++;
          if (bus_grant && !bus_halt) rd_log.push_back(address);
        end
      end else begin
        chk("idle_strobes", {address, write_enable}, 32'd0);
      end
      if (done) begin
        done_cnt++;
        chk("done_all_bytes", m_k, m_len);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_copy(input logic [23:0] s, input logic [23:0] d, input int n);
    en_cnt = 0; wr_cnt = 0; req_cnt = 0; done_cnt = 0; hold_cnt = 0;
    rd_log.delete(); wr_log.delete(); wr_dlog.delete();
    m_src = s; m_dst = d; m_len = n; m_k = 0;
    src_address = s;
    dst_address = d;
    length      = 16'(n);
    start       = 1'b1;
    st_cyc      = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_delta);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({name, "_seen"}, seen, 1);
    if (seen) chk(name, cyc - st_cyc, exp_delta);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; bus_grant = 1'b1; bus_halt = 1'b0;
    src_address = '0; dst_address = '0; length = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_ctl", {busy, done, bus_request, bus_enable, write_enable}, 32'd0);
    chk("reset_addr", address, 32'd0);
    chk("reset_data", data_out, 32'd0);
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    // 4 bytes: done is the 11th cycle counting the start cycle
    start_copy(24'h008000, 24'h00C000, 4);
    wait_done("t1_done_cycle", 10);
    repeat (2) tick();
    chk("t1_en_cycles", en_cnt, 8);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_writes", wr_cnt, 4);
    chk("t1_rd0", rd_log[0], 24'h008000);
    chk("t1_rd3", rd_log[3], 24'h008003);
    chk("t1_wr0", wr_log[0], 24'h00C000);
    chk("t1_wr3", wr_log[3], 24'h00C003);
    chk("t1_wdata0", wr_dlog[0], 8'hBC);
    chk("t1_wdata3", wr_dlog[3], 8'hBF);

    // zero length
    start_copy(24'h123456, 24'h654321, 0);
    wait_done("t2_done_cycle", 1);
    repeat (2) tick();
    chk("t2_no_enable", en_cnt, 0);
    chk("t2_no_request", req_cnt, 0);
    chk("t2_done_pulses", done_cnt, 1);

    // halt held over the first read of SD space
    bus_halt = 1'b1;
    start_copy(24'h010000, 24'h002000, 2);
    repeat (4) tick();
    bus_halt = 1'b0;
    wait_done("t3_done_cycle", 9);
    repeat (2) tick();
    chk("t3_hold_cycles", hold_cnt, 4);
    chk("t3_writes", wr_cnt, 2);
    chk("t3_wdata0", wr_dlog[0], 8'h3D);
    chk("t3_wdata1", wr_dlog[1], 8'h3C);
    chk("t3_wr1", wr_log[1], 24'h002001);

    // grant dropped during the write of byte 1
    start_copy(24'h040000, 24'h050000, 3);
    repeat (4) tick();
    bus_grant = 1'b0;
    tick();
    @(negedge clk);
    chk("t4_strobes_low", {bus_enable, write_enable}, 32'd0);
    chk("t4_req_held", bus_request, 1);
    tick();
    bus_grant = 1'b1;
    wait_done("t4_done_cycle", 12);
    repeat (2) tick();
    chk("t4_writes", wr_cnt, 3);
    chk("t4_reads", rd_log.size(), 4);
    chk("t4_reread", rd_log[2], 24'h040001);
    chk("t4_wr1", wr_log[1], 24'h050001);

    // source address wrap
    start_copy(24'hFFFFFE, 24'h000100, 3);
    wait_done("t5_done_cycle", 8);
    repeat (2) tick();
    chk("t5_rd0", rd_log[0], 24'hFFFFFE);
    chk("t5_rd1", rd_log[1], 24'hFFFFFF);
    chk("t5_rd2", rd_log[2], 24'h000000);
    chk("t5_wr2", wr_log[2], 24'h000102);

    // reset during the read of byte 2, then a clean copy
    start_copy(24'h020000, 24'h030000, 4);
    repeat (5) tick();
    @(negedge clk);
    chk("t6_pre_addr", address, 24'h020002);
    chk("t6_pre_strobes", {bus_enable, write_enable}, 32'd2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_ctl", {busy, done, bus_request, bus_enable, write_enable}, 32'd0);
    chk("t6_rst_addr", address, 32'd0);
    chk("t6_rst_data", data_out, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_no_done", done_cnt, 0);
    start_copy(24'h0A0000, 24'h0B0000, 3);
    wait_done("t6_rerun_done", 8);
    repeat (2) tick();
    chk("t6_rerun_writes", wr_cnt, 3);
    chk("t6_rerun_pulses", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
